// File: rtl/d_branch_ctrl_if.sv
// d_branch_ctrl_if: bundles the D-stage branch sequencer signals.
//   Inputs to the sequencer : i_valid, i_likely, i_useRt, i_rs, i_rt,
//                             i_E_wa, i_M_wa, i_E_tnew, i_M_tnew,
//                             i_ext_stall, i_jumpEn_of_B
//   Outputs of the sequencer: o_fwdA_sel, o_fwdB_sel, o_stall, o_br_fire,
//                             o_taken, o_nullify_ds, o_err
//   With BRANCH_STAT_EN defined: o_stat_taken, o_stat_ntaken, o_stat_stall
//   (CNT_W bits each, CNT_W only exists in that build).
// Modports: master = pipeline side (drives i_*), slave = sequencer.
interface d_branch_ctrl_if
`ifdef BRANCH_STAT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic       i_valid;
    logic       i_likely;
    logic       i_useRt;
    logic [4:0] i_rs;
    logic [4:0] i_rt;
    logic [4:0] i_E_wa;
    logic [4:0] i_M_wa;
    logic [1:0] i_E_tnew;
    logic [1:0] i_M_tnew;
    logic       i_ext_stall;
    logic       i_jumpEn_of_B;
    logic [1:0] o_fwdA_sel;
    logic [1:0] o_fwdB_sel;
    logic       o_stall;
    logic       o_br_fire;
    logic       o_taken;
    logic       o_nullify_ds;
    logic       o_err;
`ifdef BRANCH_STAT_EN
    logic [CNT_W-1:0] o_stat_taken;
    logic [CNT_W-1:0] o_stat_ntaken;
    logic [CNT_W-1:0] o_stat_stall;
`endif

    modport master (
        output i_valid, i_likely, i_useRt, i_rs, i_rt, i_E_wa, i_M_wa,
               i_E_tnew, i_M_tnew, i_ext_stall, i_jumpEn_of_B,
        input  o_fwdA_sel, o_fwdB_sel, o_stall, o_br_fire, o_taken,
               o_nullify_ds, o_err
`ifdef BRANCH_STAT_EN
        , input o_stat_taken, o_stat_ntaken, o_stat_stall
`endif
    );

    modport slave (
        input  i_valid, i_likely, i_useRt, i_rs, i_rt, i_E_wa, i_M_wa,
               i_E_tnew, i_M_tnew, i_ext_stall, i_jumpEn_of_B,
        output o_fwdA_sel, o_fwdB_sel, o_stall, o_br_fire, o_taken,
               o_nullify_ds, o_err
`ifdef BRANCH_STAT_EN
        , output o_stat_taken, o_stat_ntaken, o_stat_stall
`endif
    );
endinterface

// File: rtl/d_branch_ctrl.sv
// d_branch_ctrl: D-stage sequencer for the branch comparator.
//   Detects E/M operand hazards, selects comparator forwarding sources,
//   stalls F/D until operands are ready, fires exactly one redirect per
//   branch and issues the one-cycle delay-slot nullify for branch-likely.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - d_branch_ctrl_if.slave (all branch handshake signals)
// Parameters: MAX_STALL - stall cycle count at which o_err latches;
//   CNT_W - statistic counter width (only with BRANCH_STAT_EN).
// Optional feature macro: BRANCH_STAT_EN adds taken / not-taken / stall
//   cycle counters on o_stat_taken, o_stat_ntaken, o_stat_stall.
// o_stall, o_br_fire, o_taken and the forward selects are combinational
// (they must act in the same cycle); o_nullify_ds and o_err are registered.
// During reset every output is forced to 0.
module d_branch_ctrl #(
    parameter int MAX_STALL = 3
`ifdef BRANCH_STAT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    d_branch_ctrl_if.slave  bus
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // A source has a hazard when a younger producer still needs cycles.
    function automatic logic src_hazard(input logic [4:0] s,
                                        input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                        input logic [4:0] m_wa, input logic [1:0] m_tnew);
        return (s != 5'd0) &&
               (((s == e_wa) && (e_tnew != 2'd0)) ||
                ((s == m_wa) && (m_tnew != 2'd0)));
    endfunction

    // Forwarding source: E wins over M, register 0 always reads the regfile.
    function automatic logic [1:0] src_fwd(input logic [4:0] s,
                                           input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                           input logic [4:0] m_wa, input logic [1:0] m_tnew);
        logic [1:0] sel;
        if (s == 5'd0) begin
            sel = 2'd0;
        end else if ((s == e_wa) && (e_tnew == 2'd0)) begin
            sel = 2'd1;
        end else if ((s == m_wa) && (m_tnew == 2'd0)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          verdict_q, verdict_d;
    logic          nullify_q, nullify_d;
    logic          hazard_s;
    logic          fire_s;
    logic          taken_s;

    // Hazard detection over rs and, when compared, rt.
    always_comb begin
        hazard_s = src_hazard(bus.i_rs, bus.i_E_wa, bus.i_E_tnew, bus.i_M_wa, bus.i_M_tnew) ||
                   (bus.i_useRt &&
                    src_hazard(bus.i_rt, bus.i_E_wa, bus.i_E_tnew, bus.i_M_wa, bus.i_M_tnew));
    end

    // Next-state, stall counter, watchdog and fire decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        verdict_d = verdict_q;
        fire_s    = 1'b0;
        taken_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && hazard_s) begin
                    state_d = ST_STALL;
                    cnt_d   = ONE_CNT;
                end else if (bus.i_valid && bus.i_ext_stall) begin
                    state_d   = ST_HOLD;
                    verdict_d = bus.i_jumpEn_of_B;
                end else if (bus.i_valid) begin
                    fire_s  = 1'b1;
                    taken_s = bus.i_jumpEn_of_B;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_STALL: begin
                if (!bus.i_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (hazard_s) begin
                    cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ONE_CNT;
                end else if (bus.i_ext_stall) begin
                    state_d   = ST_HOLD;
                    verdict_d = bus.i_jumpEn_of_B;
                    cnt_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    fire_s  = 1'b1;
                    taken_s = bus.i_jumpEn_of_B;
                end
            end
            ST_HOLD: begin
                if (!bus.i_valid) begin
                    state_d = ST_IDLE;
                end else if (!bus.i_ext_stall) begin
                    state_d = ST_IDLE;
                    fire_s  = 1'b1;
                    taken_s = verdict_q;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Counter is non-zero only while stalling, so this catches the
        // cycle in which it reaches the limit (including entry when MAX_STALL=1).
        err_d     = err_q | (cnt_d == MAX_CNT);
        nullify_d = fire_s & bus.i_likely & ~taken_s;
    end

    // State, watchdog, latched verdict and nullify registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            verdict_q <= 1'b0;
            nullify_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            verdict_q <= verdict_d;
            nullify_q <= nullify_d;
        end
    end

    assign bus.o_stall      = ~reset & bus.i_valid & hazard_s;
    assign bus.o_br_fire    = ~reset & fire_s;
    assign bus.o_taken      = ~reset & fire_s & taken_s;
    assign bus.o_fwdA_sel   = reset ? 2'd0 :
        src_fwd(bus.i_rs, bus.i_E_wa, bus.i_E_tnew, bus.i_M_wa, bus.i_M_tnew);
    assign bus.o_fwdB_sel   = reset ? 2'd0 :
        src_fwd(bus.i_rt, bus.i_E_wa, bus.i_E_tnew, bus.i_M_wa, bus.i_M_tnew);
    assign bus.o_nullify_ds = nullify_q;
    assign bus.o_err        = err_q;

`ifdef BRANCH_STAT_EN
    logic [CNT_W-1:0] stat_taken_q, stat_taken_d;
    logic [CNT_W-1:0] stat_ntaken_q, stat_ntaken_d;
    logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

    // Statistic increments; counters wrap naturally.
    always_comb begin
        stat_taken_d  = stat_taken_q  + CNT_W'(bus.o_br_fire & bus.o_taken);
        stat_ntaken_d = stat_ntaken_q + CNT_W'(bus.o_br_fire & ~bus.o_taken);
        stat_stall_d  = stat_stall_q  + CNT_W'(bus.o_stall);
    end

    // Statistic counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_taken_q  <= '0;
            stat_ntaken_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_taken_q  <= stat_taken_d;
            stat_ntaken_q <= stat_ntaken_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign bus.o_stat_taken  = stat_taken_q;
    assign bus.o_stat_ntaken = stat_ntaken_q;
    assign bus.o_stat_stall  = stat_stall_q;
`endif

endmodule
